// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, HI/LO results, start/done handshake.
// Optional MULDIV_EARLY_TERM_EN: multiplies leave CALC as soon as the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int W = WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;
  logic [W-1:0]     a_r, b_r, mag_b;
  logic [2*W-1:0]   acc;
  logic             neg_lo, neg_hi;

  logic             is_div, is_sgn;
  logic [W-1:0]     mag_a_c, mag_b_c;
  logic [W:0]       mul_sum, div_trial, div_diff;
  logic [2*W-1:0]   mul_next, div_next;

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // acc holds {partial product, multiplier} for MULT and {remainder, quotient} for DIV
  always_comb begin
    is_div    = op_r[1];
    is_sgn    = ~op_r[0];
    mag_a_c   = (is_sgn && a_r[W-1]) ? -a_r : a_r;
    mag_b_c   = (is_sgn && b_r[W-1]) ? -b_r : b_r;
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc[W-1:1]};
    div_trial = acc[2*W-1:W-1];
    div_diff  = div_trial - {1'b0, mag_b};
    div_next  = div_diff[W] ? {div_trial[W-1:0], acc[W-2:0], 1'b0}
                            : {div_diff[W-1:0], acc[W-2:0], 1'b1};
  end

`ifdef MULDIV_EARLY_TERM_EN
  logic mul_rest_zero;
  always_comb begin
    mul_rest_zero = (acc[W-1:0] & ~({W{1'b1}} << cnt)) == '0;
  end
`endif

  // Control, counter and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_r     <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r     <= op;
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt <= CNT_W'(W);
          // Divide-by-zero passes through FIX without writing so done lands one edge later
          if (is_div && b_r == '0) begin
            div_zero <= 1'b1;
            state    <= S_FIX;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_FIX;
`ifdef MULDIV_EARLY_TERM_EN
          if (!is_div && mul_rest_zero) state <= S_FIX;
`endif
        end
        S_FIX: begin
          if (!div_zero) begin
            if (is_div) begin
              lo <= cond_neg(acc[W-1:0], neg_lo);
              hi <= cond_neg(acc[2*W-1:W], neg_hi);
            end else begin
              {hi, lo} <= cond_neg2(acc, neg_lo);
            end
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (start) begin
          a_r <= a;
          b_r <= b;
        end
      end
      S_LOAD: begin
        acc    <= {{W{1'b0}}, mag_a_c};
        mag_b  <= mag_b_c;
        neg_lo <= is_sgn & (a_r[W-1] ^ b_r[W-1]);
        neg_hi <= is_sgn & (is_div ? a_r[W-1] : (a_r[W-1] ^ b_r[W-1]));
      end
      S_CALC: begin
`ifdef MULDIV_EARLY_TERM_EN
        if (!is_div && mul_rest_zero) acc <= acc >> cnt;
        else                          acc <= is_div ? div_next : mul_next;
`else
        acc <= is_div ? div_next : mul_next;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit and an 8-bit instance driven with directed vectors.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start, start8;
  logic [1:0]  op, op8;
  logic [31:0] a, b, hi, lo;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy, done, div_zero, busy8, done8, dz8;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero));

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(dz8));

`ifdef MULDIV_EARLY_TERM_EN
  localparam int SMALL_MODE = 2;
`else
  localparam int SMALL_MODE = 1;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          e0;
    int          lat;
    int          mode;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_resp(input string tag, input exp_t e, input logic [31:0] h,
                            input logic [31:0] l, input logic z);
    int lat;
    lat = cyc - e.e0;
    check({tag, "_hi"}, h, e.hi);
    check({tag, "_lo"}, l, e.lo);
    check({tag, "_div_zero"}, z, e.dz);
    if (e.mode == 1) check({tag, "_latency"}, lat, e.lat);
    else begin
      checks++;
      if (lat >= e.lat) begin
        errors++;
        $display("FAIL %s_early_latency: got %0d expected below %0d", tag, lat, e.lat);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a done pulse appears
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done32: got done with empty scoreboard, required none");
        end else begin
          e = q32.pop_front();
          check_resp("w32", e, hi, lo, div_zero);
        end
      end
      if (done8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done8: got done with empty scoreboard, required none");
        end else begin
          e = q8.pop_front();
          check_resp("w8", e, {24'h0, hi8}, {24'h0, lo8}, dz8);
        end
      end
    end
  end

  task automatic issue32(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] eh, input logic [31:0] el, input logic ez,
                         input int lat, input int mode, input bit push);
    exp_t e;
    start = 1'b1; op = o; a = va; b = vb;
    e.hi = eh; e.lo = el; e.dz = ez; e.e0 = cyc + 1; e.lat = lat; e.mode = mode;
    if (push) q32.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    check("busy_after_start", busy, 1'b1);
    check("div_zero_cleared_on_start", div_zero, 1'b0);
  endtask

  task automatic issue8(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] eh, input logic [7:0] el, input logic ez,
                        input int lat, input int mode);
    exp_t e;
    start8 = 1'b1; op8 = o; a8 = va; b8 = vb;
    e.hi = {24'h0, eh}; e.lo = {24'h0, el}; e.dz = ez; e.e0 = cyc + 1; e.lat = lat; e.mode = mode;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    check("busy8_after_start", busy8, 1'b1);
  endtask

  task automatic wait_idle(input bit w8);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (w8 ? (!busy8 && !done8) : (!busy && !done)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: got still busy after 200 cycles, required idle");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; start8 = 1'b0; op = '0; op8 = '0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_div_zero", div_zero, 1'b0);
    check("reset_busy8", busy8, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Unsigned and signed multiplies
    issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 1, 1'b1);
    wait_idle(1'b0);
    issue32(2'b00, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 34, SMALL_MODE, 1'b1);
    wait_idle(1'b0);
    issue32(2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 34, 1, 1'b1);
    wait_idle(1'b0);

    // Signed and unsigned divides
    issue32(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1, 1'b1);
    wait_idle(1'b0);
    issue32(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 1, 1'b1);
    wait_idle(1'b0);

    // Preset hi/lo to 0x11/0x22, then divide by zero leaves them untouched
    issue32(2'b01, 32'h80000001, 32'h22, 32'h11, 32'h22, 1'b0, 34, 1, 1'b1);
    wait_idle(1'b0);
    issue32(2'b11, 32'd100, 32'd0, 32'h11, 32'h22, 1'b1, 2, 1, 1'b1);
    wait_idle(1'b0);
    check("div_zero_held", div_zero, 1'b1);
    issue32(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1, 1'b1);
    wait_idle(1'b0);

    // MIN / -1 with a second start pulse at E0+5 that must be ignored
    issue32(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 1, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_during_ignored_start", busy, 1'b1);
    wait_idle(1'b0);

    // Asynchronous reset mid-multiply aborts without done
    issue32(2'b00, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0, 34, 1, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    issue32(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34, SMALL_MODE, 1'b1);
    wait_idle(1'b0);

    // Narrow instance
    issue8(2'b01, 8'hFF, 8'h02, 8'h01, 8'hFE, 1'b0, 10, 1);
    wait_idle(1'b1);
    issue8(2'b01, 8'h03, 8'h02, 8'h00, 8'h06, 1'b0, 10, SMALL_MODE);
    wait_idle(1'b1);
    issue8(2'b10, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 10, 1);
    wait_idle(1'b1);
    issue8(2'b11, 8'h64, 8'h00, 8'h00, 8'h80, 1'b1, 2, 1);
    wait_idle(1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard32_drained", q32.size(), 0);
    check("scoreboard8_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
